// File: rtl/dcache_ctrl_if.sv
// Request/response bundle between the store/load buffer, the data-cache controller
// and the byte-wide memory-controller port.
interface dcache_ctrl_if #(
  parameter int NICK_W = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iSLB_en;
  logic              iSLB_ls;
  logic [NICK_W-1:0] iSLB_nick;
  logic [2:0]        iSLB_len;
  logic [ADDR_W-1:0] iSLB_addr;
  logic [DATA_W-1:0] iSLB_dt;
  logic              oSLB_en;
  logic              oSLB_done;
  logic [NICK_W-1:0] oSLB_nick;
  logic [DATA_W-1:0] oSLB_dt;
  logic              oMC_req;
  logic              iMC_gnt;
  logic              oMC_wr;
  logic [ADDR_W-1:0] oMC_addr;
  logic [7:0]        oMC_dt;
  logic [7:0]        iMC_dt;

  // The cache controller is the responder; the master side is the SLB plus memory model.
  modport slave (
    input  iSLB_en, iSLB_ls, iSLB_nick, iSLB_len, iSLB_addr, iSLB_dt, iMC_gnt, iMC_dt,
    output oSLB_en, oSLB_done, oSLB_nick, oSLB_dt, oMC_req, oMC_wr, oMC_addr, oMC_dt
  );
  modport master (
    output iSLB_en, iSLB_ls, iSLB_nick, iSLB_len, iSLB_addr, iSLB_dt, iMC_gnt, iMC_dt,
    input  oSLB_en, oSLB_done, oSLB_nick, oSLB_dt, oMC_req, oMC_wr, oMC_addr, oMC_dt
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Data-cache controller: serialises one SLB load/store into byte accesses on the
// shared memory port and returns assembled little-endian load words.
module dcache_ctrl #(
  parameter int NICK_W = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          clr,
  dcache_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, REQ, XFER, DRAIN} state_t;

  state_t            state, state_nxt;
  logic              ls_q, ls_nxt;
  logic [NICK_W-1:0] nick_q, nick_nxt;
  logic [2:0]        len_q, len_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] dt_q, dt_nxt;
  logic [DATA_W-1:0] acc_q, acc_nxt;
  logic [2:0]        cnt_q, cnt_nxt;
  logic              done_q, done_nxt;
  logic [NICK_W-1:0] rnick_q, rnick_nxt;
  logic [DATA_W-1:0] rdt_q, rdt_nxt;
  logic              req_q, req_nxt;
  logic              wr_q, wr_nxt;
  logic [ADDR_W-1:0] maddr_q, maddr_nxt;
  logic [7:0]        mdt_q, mdt_nxt;
  logic              accept, last_byte;
  logic [1:0]        cap_idx, nxt_idx;

  assign bus.oSLB_en   = (state == IDLE) & ~rst & ~clr & rdy;
  assign bus.oSLB_done = done_q;
  assign bus.oSLB_nick = rnick_q;
  assign bus.oSLB_dt   = rdt_q;
  assign bus.oMC_req   = req_q;
  assign bus.oMC_wr    = wr_q;
  assign bus.oMC_addr  = maddr_q;
  assign bus.oMC_dt    = mdt_q;

  assign accept    = bus.iSLB_en & bus.oSLB_en;
  assign last_byte = (cnt_q == len_q - 3'd1);
  // In DRAIN cnt equals len, so the 2-bit wrap of cnt-1 still names the final byte.
  assign cap_idx   = cnt_q[1:0] - 2'd1;
  assign nxt_idx   = cnt_q[1:0] + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ls_q    <= 1'b0;
      nick_q  <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      dt_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      rnick_q <= '0;
      rdt_q   <= '0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      maddr_q <= '0;
      mdt_q   <= '0;
    end else begin
      state   <= state_nxt;
      ls_q    <= ls_nxt;
      nick_q  <= nick_nxt;
      len_q   <= len_nxt;
      addr_q  <= addr_nxt;
      dt_q    <= dt_nxt;
      acc_q   <= acc_nxt;
      cnt_q   <= cnt_nxt;
      done_q  <= done_nxt;
      rnick_q <= rnick_nxt;
      rdt_q   <= rdt_nxt;
      req_q   <= req_nxt;
      wr_q    <= wr_nxt;
      maddr_q <= maddr_nxt;
      mdt_q   <= mdt_nxt;
    end
  end

  // A flush kills loads anywhere and stores still waiting for grant; a granted store is committed.
  always_comb begin
    state_nxt = state;
    if (rdy) begin
      case (state)
        IDLE:  if (accept) state_nxt = REQ;
        REQ:   if (clr) state_nxt = IDLE;
               else if (bus.iMC_gnt) state_nxt = XFER;
        XFER:  if (clr && !ls_q) state_nxt = IDLE;
               else if (last_byte) state_nxt = ls_q ? IDLE : DRAIN;
        DRAIN: state_nxt = IDLE;
      endcase
    end
  end

  // Memory-port outputs are registered, so each step prepares the byte for the next cycle.
  always_comb begin
    ls_nxt    = ls_q;
    nick_nxt  = nick_q;
    len_nxt   = len_q;
    addr_nxt  = addr_q;
    dt_nxt    = dt_q;
    acc_nxt   = acc_q;
    cnt_nxt   = cnt_q;
    done_nxt  = done_q;
    rnick_nxt = rnick_q;
    rdt_nxt   = rdt_q;
    req_nxt   = req_q;
    wr_nxt    = wr_q;
    maddr_nxt = maddr_q;
    mdt_nxt   = mdt_q;
    if (rdy) begin
      done_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ls_nxt   = bus.iSLB_ls;
            nick_nxt = bus.iSLB_nick;
            len_nxt  = bus.iSLB_len;
            addr_nxt = bus.iSLB_addr;
            dt_nxt   = bus.iSLB_dt;
            acc_nxt  = '0;
            cnt_nxt  = '0;
            req_nxt  = 1'b1;
            wr_nxt   = 1'b0;
          end
        end
        REQ: begin
          if (clr) begin
            req_nxt = 1'b0;
          end else if (bus.iMC_gnt) begin
            cnt_nxt   = '0;
            maddr_nxt = addr_q;
            mdt_nxt   = dt_q[7:0];
            wr_nxt    = ls_q;
          end
        end
        XFER: begin
          if (cnt_q != 3'd0) acc_nxt[8*cap_idx +: 8] = bus.iMC_dt;
          if ((clr && !ls_q) || last_byte) begin
            req_nxt = 1'b0;
            wr_nxt  = 1'b0;
            cnt_nxt = (clr || ls_q) ? 3'd0 : cnt_q + 3'd1;
          end else begin
            cnt_nxt   = cnt_q + 3'd1;
            maddr_nxt = addr_q + ADDR_W'(nxt_idx);
            mdt_nxt   = dt_q[8*nxt_idx +: 8];
          end
        end
        DRAIN: begin
          acc_nxt[8*cap_idx +: 8] = bus.iMC_dt;
          cnt_nxt = '0;
          if (!clr) begin
            done_nxt  = 1'b1;
            rnick_nxt = nick_q;
            rdt_nxt   = acc_nxt;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed testbench for dcache_ctrl with a byte-wide memory model behind the MC port.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rst, rdy, clr;
  logic [7:0] mem [0:1023];
  logic prev_req, prev_gnt;
  logic xfer_cycle;
  int compared = 0;
  int mismatched = 0;

  dcache_ctrl_if #(.NICK_W(4), .ADDR_W(32), .DATA_W(32)) bus ();

  dcache_ctrl #(.NICK_W(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // A transfer cycle is any cycle where the request was already up and granted last cycle.
  assign xfer_cycle = prev_req & prev_gnt & bus.oMC_req;

  always @(posedge clk) begin
    if (rst) begin
      prev_req <= 1'b0;
      prev_gnt <= 1'b0;
    end else if (rdy) begin
      if (xfer_cycle && bus.oMC_wr) mem[bus.oMC_addr[9:0]] <= bus.oMC_dt;
      bus.iMC_dt <= mem[bus.oMC_addr[9:0]];
      prev_req <= bus.oMC_req;
      prev_gnt <= bus.iMC_gnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ls, input logic [3:0] nick, input logic [2:0] len,
                       input logic [31:0] addr, input logic [31:0] dt);
    bus.iSLB_en   = 1'b1;
    bus.iSLB_ls   = ls;
    bus.iSLB_nick = nick;
    bus.iSLB_len  = len;
    bus.iSLB_addr = addr;
    bus.iSLB_dt   = dt;
    tick();
    bus.iSLB_en = 1'b0;
  endtask

  task automatic wait_done(input int start, output int done_edge, output int rd_cnt);
    int n;
    n = start;
    done_edge = -1;
    rd_cnt = 0;
    for (int k = 0; k < 40 && done_edge < 0; k++) begin
      tick();
      n++;
      if (xfer_cycle && !bus.oMC_wr && rdy) rd_cnt++;
      if (bus.oSLB_done) done_edge = n;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    compared++; if (bus.oSLB_done !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_done: got %b want 0", bus.oSLB_done); end
    compared++; if (bus.oSLB_nick !== 4'h0) begin mismatched++; $display("[TB] FAIL rst_nick: got %h want 0", bus.oSLB_nick); end
    compared++; if (bus.oSLB_dt !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_dt: got %h want 0", bus.oSLB_dt); end
    compared++; if (bus.oMC_req !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_req: got %b want 0", bus.oMC_req); end
    compared++; if (bus.oMC_wr !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_wr: got %b want 0", bus.oMC_wr); end
    compared++; if (bus.oMC_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_addr: got %h want 0", bus.oMC_addr); end
    compared++; if (bus.oMC_dt !== 8'h0) begin mismatched++; $display("[TB] FAIL rst_mdt: got %h want 0", bus.oMC_dt); end
    compared++; if (bus.oSLB_en !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_en_low: got %b want 0", bus.oSLB_en); end
    rst = 1'b0;
    #1;
    compared++; if (bus.oSLB_en !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_en_high: got %b want 1", bus.oSLB_en); end
  endtask

  task automatic test_load_word();
    int de, rc;
    mem[10'h100] <= 8'h11; mem[10'h101] <= 8'h22; mem[10'h102] <= 8'h33; mem[10'h103] <= 8'h44;
    issue(1'b0, 4'd5, 3'd4, 32'h100, 32'h0);
    wait_done(0, de, rc);
    compared++; if (de !== 6) begin mismatched++; $display("[TB] FAIL lw_latency: got %0d want 6", de); end
    compared++; if (bus.oSLB_dt !== 32'h44332211) begin mismatched++; $display("[TB] FAIL lw_data: got %h want 44332211", bus.oSLB_dt); end
    compared++; if (bus.oSLB_nick !== 4'd5) begin mismatched++; $display("[TB] FAIL lw_nick: got %0d want 5", bus.oSLB_nick); end
    compared++; if (rc !== 4) begin mismatched++; $display("[TB] FAIL lw_reads: got %0d want 4", rc); end
    compared++; if (bus.oSLB_en !== 1'b1) begin mismatched++; $display("[TB] FAIL lw_en_at_done: got %b want 1", bus.oSLB_en); end
    tick();
    compared++; if (bus.oSLB_done !== 1'b0) begin mismatched++; $display("[TB] FAIL lw_done_pulse: got %b want 0", bus.oSLB_done); end
    compared++; if (bus.oSLB_dt !== 32'h44332211) begin mismatched++; $display("[TB] FAIL lw_data_hold: got %h want 44332211", bus.oSLB_dt); end
  endtask

  task automatic test_load_byte();
    int de, rc;
    mem[10'h007] <= 8'h9C;
    issue(1'b0, 4'd3, 3'd1, 32'h7, 32'h0);
    wait_done(0, de, rc);
    compared++; if (de !== 3) begin mismatched++; $display("[TB] FAIL lb_latency: got %0d want 3", de); end
    compared++; if (bus.oSLB_dt !== 32'h0000009C) begin mismatched++; $display("[TB] FAIL lb_data: got %h want 0000009c", bus.oSLB_dt); end
    compared++; if (bus.oSLB_nick !== 4'd3) begin mismatched++; $display("[TB] FAIL lb_nick: got %0d want 3", bus.oSLB_nick); end
    compared++; if (rc !== 1) begin mismatched++; $display("[TB] FAIL lb_reads: got %0d want 1", rc); end
    tick();
  endtask

  task automatic test_store_half();
    int en_edge;
    int done_seen;
    mem[10'h202] <= 8'h00; mem[10'h203] <= 8'h00; mem[10'h204] <= 8'h5A;
    issue(1'b1, 4'd7, 3'd2, 32'h202, 32'h1234BEEF);
    en_edge = -1;
    done_seen = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (bus.oSLB_done) done_seen++;
      if (bus.oSLB_en && en_edge < 0) en_edge = n;
    end
    compared++; if (en_edge !== 3) begin mismatched++; $display("[TB] FAIL sh_en_latency: got %0d want 3", en_edge); end
    compared++; if (done_seen !== 0) begin mismatched++; $display("[TB] FAIL sh_no_done: got %0d pulses want 0", done_seen); end
    compared++; if (mem[10'h202] !== 8'hEF) begin mismatched++; $display("[TB] FAIL sh_byte0: got %h want ef", mem[10'h202]); end
    compared++; if (mem[10'h203] !== 8'hBE) begin mismatched++; $display("[TB] FAIL sh_byte1: got %h want be", mem[10'h203]); end
    compared++; if (mem[10'h204] !== 8'h5A) begin mismatched++; $display("[TB] FAIL sh_byte2_untouched: got %h want 5a", mem[10'h204]); end
    compared++; if (bus.oSLB_dt !== 32'h0000009C) begin mismatched++; $display("[TB] FAIL sh_dt_hold: got %h want 0000009c", bus.oSLB_dt); end
  endtask

  task automatic test_grant_delay();
    int de, rc;
    logic [31:0] a0;
    bus.iMC_gnt = 1'b0;
    a0 = bus.oMC_addr;
    issue(1'b0, 4'd9, 3'd4, 32'h100, 32'h0);
    for (int n = 1; n <= 5; n++) begin
      tick();
      compared++; if (bus.oMC_req !== 1'b1) begin mismatched++; $display("[TB] FAIL gnt_req_edge%0d: got %b want 1", n, bus.oMC_req); end
      compared++; if (bus.oMC_addr !== a0) begin mismatched++; $display("[TB] FAIL gnt_addr_edge%0d: got %h want %h", n, bus.oMC_addr, a0); end
    end
    bus.iMC_gnt = 1'b1;
    wait_done(5, de, rc);
    compared++; if (de !== 11) begin mismatched++; $display("[TB] FAIL gnt_latency: got %0d want 11", de); end
    compared++; if (bus.oSLB_dt !== 32'h44332211) begin mismatched++; $display("[TB] FAIL gnt_data: got %h want 44332211", bus.oSLB_dt); end
    compared++; if (bus.oSLB_nick !== 4'd9) begin mismatched++; $display("[TB] FAIL gnt_nick: got %0d want 9", bus.oSLB_nick); end
    tick();
  endtask

  task automatic test_flush();
    int done_seen;
    issue(1'b0, 4'd2, 3'd4, 32'h100, 32'h0);
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    compared++; if (bus.oSLB_en !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_lw_idle: got %b want 1", bus.oSLB_en); end
    compared++; if (bus.oMC_req !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_lw_req: got %b want 0", bus.oMC_req); end
    done_seen = 0;
    for (int n = 0; n < 8; n++) begin tick(); if (bus.oSLB_done) done_seen++; end
    compared++; if (done_seen !== 0) begin mismatched++; $display("[TB] FAIL flush_lw_no_done: got %0d pulses want 0", done_seen); end
    compared++; if (bus.oSLB_nick !== 4'd9) begin mismatched++; $display("[TB] FAIL flush_lw_nick_hold: got %0d want 9", bus.oSLB_nick); end
    mem[10'h040] <= 8'h00; mem[10'h041] <= 8'h00; mem[10'h042] <= 8'h00; mem[10'h043] <= 8'h00;
    issue(1'b1, 4'd1, 3'd4, 32'h40, 32'hAABBCCDD);
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int n = 0; n < 8; n++) tick();
    compared++; if ({mem[10'h043], mem[10'h042], mem[10'h041], mem[10'h040]} !== 32'hAABBCCDD) begin
      mismatched++;
      $display("[TB] FAIL flush_sw_bytes: got %h%h%h%h want aabbccdd", mem[10'h043], mem[10'h042], mem[10'h041], mem[10'h040]);
    end
  endtask

  task automatic test_rdy_stall();
    int de, rc;
    logic [31:0] a_frz;
    issue(1'b0, 4'd6, 3'd4, 32'h100, 32'h0);
    tick();
    tick();
    rdy = 1'b0;
    a_frz = bus.oMC_addr;
    for (int n = 3; n <= 5; n++) begin
      tick();
      compared++; if (bus.oMC_req !== 1'b1 || bus.oMC_addr !== a_frz) begin
        mismatched++;
        $display("[TB] FAIL rdy_freeze_edge%0d: got req=%b addr=%h want req=1 addr=%h", n, bus.oMC_req, bus.oMC_addr, a_frz);
      end
    end
    rdy = 1'b1;
    wait_done(5, de, rc);
    compared++; if (de !== 9) begin mismatched++; $display("[TB] FAIL rdy_latency: got %0d want 9", de); end
    compared++; if (bus.oSLB_dt !== 32'h44332211) begin mismatched++; $display("[TB] FAIL rdy_data: got %h want 44332211", bus.oSLB_dt); end
    compared++; if (bus.oSLB_nick !== 4'd6) begin mismatched++; $display("[TB] FAIL rdy_nick: got %0d want 6", bus.oSLB_nick); end
    tick();
  endtask

  task automatic test_reset_mid();
    int done_seen;
    issue(1'b1, 4'd4, 3'd4, 32'h300, 32'hCAFEF00D);
    tick();
    tick();
    rst = 1'b1;
    tick();
    compared++; if ({bus.oSLB_done, bus.oMC_req, bus.oMC_wr} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL rstmid_ctl: got done=%b req=%b wr=%b want 000", bus.oSLB_done, bus.oMC_req, bus.oMC_wr);
    end
    compared++; if (bus.oSLB_nick !== 4'h0 || bus.oSLB_dt !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL rstmid_slb: got nick=%h dt=%h want 0 0", bus.oSLB_nick, bus.oSLB_dt);
    end
    compared++; if (bus.oMC_addr !== 32'h0 || bus.oMC_dt !== 8'h0) begin
      mismatched++;
      $display("[TB] FAIL rstmid_mc: got addr=%h dt=%h want 0 0", bus.oMC_addr, bus.oMC_dt);
    end
    rst = 1'b0;
    done_seen = 0;
    for (int n = 0; n < 6; n++) begin tick(); if (bus.oSLB_done || bus.oMC_req) done_seen++; end
    compared++; if (done_seen !== 0 || bus.oSLB_en !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rstmid_idle: got activity=%0d en=%b want 0 1", done_seen, bus.oSLB_en);
    end
  endtask

  task automatic test_back_to_back();
    int de, rc;
    issue(1'b0, 4'd8, 3'd1, 32'h7, 32'h0);
    wait_done(0, de, rc);
    compared++; if (de !== 3 || bus.oSLB_dt !== 32'h9C) begin
      mismatched++;
      $display("[TB] FAIL b2b_first: got edge=%0d dt=%h want 3 0000009c", de, bus.oSLB_dt);
    end
    compared++; if (bus.oSLB_en !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_en_with_done: got %b want 1", bus.oSLB_en); end
    issue(1'b0, 4'd4, 3'd2, 32'h102, 32'h0);
    wait_done(0, de, rc);
    compared++; if (de !== 4) begin mismatched++; $display("[TB] FAIL b2b_latency: got %0d want 4", de); end
    compared++; if (bus.oSLB_dt !== 32'h00004433) begin mismatched++; $display("[TB] FAIL b2b_data: got %h want 00004433", bus.oSLB_dt); end
    compared++; if (bus.oSLB_nick !== 4'd4) begin mismatched++; $display("[TB] FAIL b2b_nick: got %0d want 4", bus.oSLB_nick); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    clr = 1'b0;
    bus.iSLB_en   = 1'b0;
    bus.iSLB_ls   = 1'b0;
    bus.iSLB_nick = '0;
    bus.iSLB_len  = 3'd0;
    bus.iSLB_addr = '0;
    bus.iSLB_dt   = '0;
    bus.iMC_gnt   = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_grant_delay();
    test_flush();
    test_rdy_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
